// File: rtl/countdown_timer.sv
// Countdown timer: minutes/seconds down-counter with a 1 Hz prescaler.
//
// Parameters:
//   TICK_DIV     - clk cycles per one-second decrement.
// Ports:
//   clk_i        - system clock; all state changes on the rising edge.
//   rst_i        - asynchronous, active-high reset.
//   load_i       - one-cycle pulse; captures load_min_i/load_sec_i (clamped to 59).
//   load_min_i   - preset minutes, 0-63.
//   load_sec_i   - preset seconds, 0-63.
//   start_i      - one-cycle pulse; begins or resumes counting.
//   stop_i       - one-cycle pulse; pauses counting.
//   minutes_o    - minutes remaining.
//   seconds_o    - seconds remaining.
//   running_o    - high while counting.
//   done_o       - one-cycle pulse when the count reaches 00:00.
//   expired_o    - high while the timer sits expired at 00:00.
module countdown_timer #(
    parameter int unsigned TICK_DIV = 100_000_000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic [5:0] load_min_i,
    input  logic [5:0] load_sec_i,
    input  logic       start_i,
    input  logic       stop_i,
    output logic [5:0] minutes_o,
    output logic [5:0] seconds_o,
    output logic       running_o,
    output logic       done_o,
    output logic       expired_o
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PrescMax = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StPause,
        StExpired
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [5:0]    min_q, min_d;
    logic [5:0]    sec_q, sec_d;
    logic          done_q, done_d;
    logic          running_q, running_d;
    logic          expired_q, expired_d;

    logic          tick;
    logic          count_nz;

    assign tick     = (state_q == StRun) && (presc_q == PrescMax);
    assign count_nz = (min_q != 6'd0) || (sec_q != 6'd0);

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        min_d   = min_q;
        sec_d   = sec_q;
        done_d  = 1'b0;

        if (load_i) begin
            // Load wins over start/stop and restarts from a clean idle state.
            state_d = StIdle;
            presc_d = '0;
            min_d   = (load_min_i > 6'd59) ? 6'd59 : load_min_i;
            sec_d   = (load_sec_i > 6'd59) ? 6'd59 : load_sec_i;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i && !stop_i && count_nz) begin
                        state_d = StRun;
                        presc_d = '0;
                    end
                end
                StRun: begin
                    presc_d = tick ? '0 : presc_q + PW'(1);
                    if (tick) begin
                        if (sec_q != 6'd0) begin
                            sec_d = sec_q - 6'd1;
                        end else begin
                            sec_d = 6'd59;
                            min_d = min_q - 6'd1;
                        end
                    end
                    // Reaching 00:00 on this tick takes precedence over a pause.
                    if (tick && min_q == 6'd0 && sec_q == 6'd1) begin
                        state_d = StExpired;
                        done_d  = 1'b1;
                    end else if (stop_i) begin
                        state_d = StPause;
                    end
                end
                StPause: begin
                    // Prescaler is kept so the resumed second is not lengthened.
                    if (start_i && !stop_i && count_nz) begin
                        state_d = StRun;
                    end
                end
                StExpired: begin
                end
                default: state_d = StIdle;
            endcase
        end

        // Status flags are registered copies of the next state so they never glitch.
        running_d = (state_d == StRun);
        expired_d = (state_d == StExpired);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            presc_q   <= '0;
            min_q     <= 6'd0;
            sec_q     <= 6'd0;
            done_q    <= 1'b0;
            running_q <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            min_q     <= min_d;
            sec_q     <= sec_d;
            done_q    <= done_d;
            running_q <= running_d;
            expired_q <= expired_d;
        end
    end

    assign minutes_o = min_q;
    assign seconds_o = sec_q;
    assign running_o = running_q;
    assign done_o    = done_q;
    assign expired_o = expired_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer with TICK_DIV = 4.
module tb_countdown_timer;

    logic       clk;
    logic       rst;
    logic       load;
    logic [5:0] load_min;
    logic [5:0] load_sec;
    logic       start;
    logic       stop;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       running;
    logic       done;
    logic       expired;

    int checks = 0;
    int errors = 0;

    countdown_timer #(
        .TICK_DIV(4)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .load_i    (load),
        .load_min_i(load_min),
        .load_sec_i(load_sec),
        .start_i   (start),
        .stop_i    (stop),
        .minutes_o (minutes),
        .seconds_o (seconds),
        .running_o (running),
        .done_o    (done),
        .expired_o (expired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       load;
        logic [5:0] lmin;
        logic [5:0] lsec;
        logic       start;
        logic       stop;
        logic [5:0] emin;
        logic [5:0] esec;
        logic       erun;
        logic       eexp;
        logic       edone;
    } vec_t;

    localparam int NVEC = 23;
    vec_t vecs [NVEC];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input int m, input int s,
                             input int r, input int e, input int d);
        check({tag, " minutes"}, int'(minutes), m);
        check({tag, " seconds"}, int'(seconds), s);
        check({tag, " running"}, int'(running), r);
        check({tag, " expired"}, int'(expired), e);
        check({tag, " done"}, int'(done), d);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic l, input logic [5:0] m, input logic [5:0] s,
                         input logic st, input logic sp);
        load = l; load_min = m; load_sec = s; start = st; stop = sp;
        @(posedge clk);
        #1;
        load = 1'b0; start = 1'b0; stop = 1'b0;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; load_min = 6'd0; load_sec = 6'd0;
        start = 1'b0; stop = 1'b0;

        // One row per clock: inputs applied for one cycle, outputs checked after the edge.
        vecs[0]  = '{1'b1, 6'd63, 6'd63, 1'b0, 1'b0, 6'd59, 6'd59, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 6'd0,  6'd0,  1'b0, 1'b0, 6'd0,  6'd0,  1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 6'd0,  6'd0,  1'b1, 1'b0, 6'd0,  6'd0,  1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 6'd0,  6'd5,  1'b1, 1'b1, 6'd0,  6'd5,  1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 6'd0,  6'd0,  1'b0, 1'b0, 6'd0,  6'd5,  1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 6'd0,  6'd0,  1'b0, 1'b0, 6'd0,  6'd5,  1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 6'd10, 6'd0,  1'b0, 1'b0, 6'd10, 6'd0,  1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 6'd0,  6'd0,  1'b1, 1'b0, 6'd10, 6'd0,  1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 6'd0,  6'd0,  1'b0, 1'b0, 6'd10, 6'd0,  1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 6'd0,  6'd0,  1'b0, 1'b0, 6'd10, 6'd0,  1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 6'd0,  6'd0,  1'b0, 1'b0, 6'd10, 6'd0,  1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 6'd0,  6'd0,  1'b0, 1'b0, 6'd9,  6'd59, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 6'd0,  6'd0,  1'b0, 1'b1, 6'd9,  6'd59, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 6'd0,  6'd0,  1'b0, 1'b0, 6'd9,  6'd59, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 6'd0,  6'd1,  1'b0, 1'b0, 6'd0,  6'd1,  1'b0, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 6'd0,  6'd0,  1'b1, 1'b0, 6'd0,  6'd1,  1'b1, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 6'd0,  6'd0,  1'b0, 1'b0, 6'd0,  6'd1,  1'b1, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 6'd0,  6'd0,  1'b0, 1'b0, 6'd0,  6'd1,  1'b1, 1'b0, 1'b0};
        vecs[18] = '{1'b0, 6'd0,  6'd0,  1'b0, 1'b0, 6'd0,  6'd1,  1'b1, 1'b0, 1'b0};
        vecs[19] = '{1'b0, 6'd0,  6'd0,  1'b0, 1'b0, 6'd0,  6'd0,  1'b0, 1'b1, 1'b1};
        vecs[20] = '{1'b0, 6'd0,  6'd0,  1'b0, 1'b0, 6'd0,  6'd0,  1'b0, 1'b1, 1'b0};
        vecs[21] = '{1'b0, 6'd0,  6'd0,  1'b1, 1'b0, 6'd0,  6'd0,  1'b0, 1'b1, 1'b0};
        vecs[22] = '{1'b1, 6'd0,  6'd3,  1'b0, 1'b0, 6'd0,  6'd3,  1'b0, 1'b0, 1'b0};

        // Reset state, before any clock edge.
        #2;
        check_out("reset", 0, 0, 0, 0, 0);
        step(1);
        rst = 1'b0;

        // Table-driven vectors.
        for (int i = 0; i < NVEC; i++) begin
            pulse(vecs[i].load, vecs[i].lmin, vecs[i].lsec, vecs[i].start, vecs[i].stop);
            check_out($sformatf("vec%0d", i), int'(vecs[i].emin), int'(vecs[i].esec),
                      int'(vecs[i].erun), int'(vecs[i].eexp), int'(vecs[i].edone));
        end

        // Scenario 1: first decrement exactly TICK_DIV cycles after start.
        reset_dut();
        pulse(1'b1, 6'd1, 6'd2, 1'b0, 1'b0);
        pulse(1'b0, 6'd0, 6'd0, 1'b1, 1'b0);
        step(3);
        check_out("s1 t3", 1, 2, 1, 0, 0);
        step(1);
        check_out("s1 t4", 1, 1, 1, 0, 0);
        step(4);
        check_out("s1 t8", 1, 0, 1, 0, 0);
        step(4);
        check_out("s1 t12", 0, 59, 1, 0, 0);

        // Scenario 2: expiry, single done pulse, start ignored afterwards.
        reset_dut();
        pulse(1'b1, 6'd0, 6'd2, 1'b0, 1'b0);
        pulse(1'b0, 6'd0, 6'd0, 1'b1, 1'b0);
        step(3);
        check_out("s2 t3", 0, 2, 1, 0, 0);
        step(1);
        check_out("s2 t4", 0, 1, 1, 0, 0);
        step(3);
        check_out("s2 t7", 0, 1, 1, 0, 0);
        step(1);
        check_out("s2 t8", 0, 0, 0, 1, 1);
        step(1);
        check_out("s2 t9", 0, 0, 0, 1, 0);
        pulse(1'b0, 6'd0, 6'd0, 1'b1, 1'b0);
        step(2);
        check_out("s2 late start", 0, 0, 0, 1, 0);

        // Scenario 3: pause keeps the prescaler; resume finishes the partial second.
        reset_dut();
        pulse(1'b1, 6'd0, 6'd5, 1'b0, 1'b0);
        pulse(1'b0, 6'd0, 6'd0, 1'b1, 1'b0);
        step(4);
        check_out("s3 t4", 0, 4, 1, 0, 0);
        step(1);
        pulse(1'b0, 6'd0, 6'd0, 1'b0, 1'b1);
        check_out("s3 stop", 0, 4, 0, 0, 0);
        step(20);
        check_out("s3 paused", 0, 4, 0, 0, 0);
        pulse(1'b0, 6'd0, 6'd0, 1'b1, 1'b0);
        check_out("s3 resume", 0, 4, 1, 0, 0);
        step(1);
        check_out("s3 resume+1", 0, 4, 1, 0, 0);
        step(1);
        check_out("s3 resume+2", 0, 3, 1, 0, 0);

        // Scenario 6: asynchronous reset mid-count, then no counting until reload.
        reset_dut();
        pulse(1'b1, 6'd0, 6'd30, 1'b0, 1'b0);
        pulse(1'b0, 6'd0, 6'd0, 1'b1, 1'b0);
        step(2);
        check_out("s6 running", 0, 30, 1, 0, 0);
        #3;
        rst = 1'b1;
        #1;
        check_out("s6 async", 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(10);
        check_out("s6 after", 0, 0, 0, 0, 0);
        pulse(1'b1, 6'd0, 6'd2, 1'b0, 1'b0);
        check_out("s6 reload", 0, 2, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
